// File: rtl/memoria_bist.sv
// BIST controller for the data memory: two write-then-read sweeps with
// complementary patterns, reporting the mismatch count and the first failing address.
module memoria_bist #(
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_DADO = 8   // must not exceed LARGURA_END
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Iniciar,
  input  logic [LARGURA_DADO-1:0] Semente,
  output logic [LARGURA_END-1:0]  Endereco,
  output logic [LARGURA_DADO-1:0] DadoEscr,
  output logic                    MenWrite,
  output logic                    MenRead,
  input  logic [LARGURA_DADO-1:0] DadoLido,
  output logic                    Ocupado,
  output logic                    Concluido,
  output logic                    Falha,
  output logic [LARGURA_END+1:0]  NumErros,
  output logic [LARGURA_END-1:0]  PrimeiroEndErro
);

  // state   | meaning
  // OCIOSO  | idle after reset, waiting for Iniciar
  // ESCRITA | writing P(end_cnt) to every address
  // LEITURA | reading back every address and comparing with P(end_cnt)
  // FIM     | run complete, results held until Iniciar
  typedef enum logic [1:0] {OCIOSO, ESCRITA, LEITURA, FIM} estado_t;

  localparam logic [LARGURA_END-1:0] UM_END = 1;
  localparam logic [LARGURA_END+1:0] UM_ERR = 1;

  estado_t                 estado, prox;
  logic [LARGURA_END-1:0]  end_cnt;
  logic                    passo;
  logic [LARGURA_DADO-1:0] semente_r;
  logic [LARGURA_DADO-1:0] base, padrao;
  logic                    ultimo, inicio, erro;

  assign ultimo = &end_cnt;
  assign inicio = ((estado == OCIOSO) || (estado == FIM)) && Iniciar;
  assign erro   = (estado == LEITURA) && (DadoLido != padrao);

  always_comb begin
    base   = end_cnt[LARGURA_DADO-1:0] ^ semente_r;
    padrao = passo ? ~base : base;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  // Bus controls are decoded from state so an async reset drops them at once.
  always_comb begin
    prox      = estado;
    MenWrite  = 1'b0;
    MenRead   = 1'b0;
    Ocupado   = 1'b0;
    Concluido = 1'b0;
    Endereco  = '0;
    DadoEscr  = '0;
    case (estado)
      OCIOSO: begin
        if (Iniciar) prox = ESCRITA;
      end
      ESCRITA: begin
        MenWrite = 1'b1;
        Ocupado  = 1'b1;
        Endereco = end_cnt;
        DadoEscr = padrao;
        if (ultimo) prox = LEITURA;
      end
      LEITURA: begin
        MenRead  = 1'b1;
        Ocupado  = 1'b1;
        Endereco = end_cnt;
        if (ultimo) prox = passo ? FIM : ESCRITA;
      end
      FIM: begin
        Concluido = 1'b1;
        if (Iniciar) prox = ESCRITA;
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      end_cnt         <= '0;
      passo           <= 1'b0;
      semente_r       <= '0;
      NumErros        <= '0;
      Falha           <= 1'b0;
      PrimeiroEndErro <= '0;
    end else if (inicio) begin
      end_cnt         <= '0;
      passo           <= 1'b0;
      semente_r       <= Semente;
      NumErros        <= '0;
      Falha           <= 1'b0;
      PrimeiroEndErro <= '0;
    end else if ((estado == ESCRITA) || (estado == LEITURA)) begin
      end_cnt <= end_cnt + UM_END;
      if ((estado == LEITURA) && ultimo) passo <= 1'b1;
      if (erro) begin
        NumErros <= NumErros + UM_ERR;
        if (!Falha) begin
          Falha           <= 1'b1;
          PrimeiroEndErro <= end_cnt;
        end
      end
    end
  end

endmodule

// File: doc/memoria_bist.md
# memoria_bist

Built-in self-test controller for the data memory (`MenoriaDados`). It is the initiator side of that memory's port: it drives `Endereco`, `DadoEscr`, `MenWrite` and `MenRead`, and checks `DadoLido`. It sweeps every address in two write-then-read passes with complementary data patterns and reports the error count and the first failing address. It sits beside the datapath and owns the memory port only while `Ocupado=1`; muxing with the CPU is outside this block.

## Interface
- `LARGURA_END`, default 8: address width; the sweep covers 2^LARGURA_END words.
- `LARGURA_DADO`, default 8: data width; must be ≤ LARGURA_END.
- `Clock` input 1: single clock; all state changes on rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Iniciar` input 1: start request, sampled only in OCIOSO and FIM.
- `Semente` input LARGURA_DADO: pattern seed, captured at start.
- `Endereco` output LARGURA_END: memory address.
- `DadoEscr` output LARGURA_DADO: memory write data.
- `MenWrite` output 1: memory write enable.
- `MenRead` output 1: memory read enable.
- `DadoLido` input LARGURA_DADO: memory read data.
- `Ocupado` output 1: test in progress.
- `Concluido` output 1: test finished; held until restart or reset.
- `Falha` output 1: at least one mismatch recorded.
- `NumErros` output LARGURA_END+2: mismatch count; max 2·2^LARGURA_END, no overflow.
- `PrimeiroEndErro` output LARGURA_END: address of the first mismatch.

## Operation
- States: OCIOSO, ESCRITA, LEITURA, FIM. Registers: `end_cnt` (LARGURA_END), `passo` (1 bit), `semente_r`.
- Pattern: P(a) = a[LARGURA_DADO-1:0] ^ semente_r when passo=0, and ~(a ^ semente_r) when passo=1.
- OCIOSO or FIM with `Iniciar`=1 at the edge:
  - capture `Semente`, clear `end_cnt`, `passo`, `NumErros`, `Falha` and `PrimeiroEndErro`;
  - go to ESCRITA.
- ESCRITA:
  - `MenWrite`=1, `MenRead`=0, `Endereco`=`end_cnt`, `DadoEscr`=P(`end_cnt`);
  - each edge increments `end_cnt`; at the edge where `end_cnt` is the all-ones value, wrap to 0 and go to LEITURA.
- LEITURA:
  - `MenRead`=1, `MenWrite`=0, `Endereco`=`end_cnt`;
  - `DadoLido` is sampled on the edge that ends the cycle and compared with P(`end_cnt`);
  - on mismatch: `NumErros`+1; if `Falha` was 0, set `Falha` and load `PrimeiroEndErro`=`end_cnt`;
  - at the all-ones address, wrap to 0. If `passo`=0, set `passo`=1 and go to ESCRITA; otherwise go to FIM.
- FIM: `Concluido`=1 and results held. `Iniciar` restarts.
- `Iniciar` in ESCRITA or LEITURA is ignored.
- `Ocupado`=1 exactly in ESCRITA and LEITURA. `MenWrite` and `MenRead` are decoded from state and are never both 1.
- Outside ESCRITA, `DadoEscr`=0. Outside ESCRITA and LEITURA, `Endereco`=0.

## Timing
- Reset asserted, at any time including mid-sweep:
  - state=OCIOSO;
  - `MenWrite`, `MenRead`, `Ocupado`, `Concluido` and `Falha` go to 0 immediately, without waiting for a clock edge;
  - `Endereco`, `DadoEscr`, `NumErros` and `PrimeiroEndErro` go to 0.
- The first edge with `Reset`=1 and `Iniciar`=1 starts a run.
- Start edge S:
  - cycles S+1 … S+N (N = 2^LARGURA_END) write pass 0;
  - S+N+1 … S+2N read pass 0;
  - S+2N+1 … S+3N write pass 1;
  - S+3N+1 … S+4N read pass 1.
- `Concluido` rises after edge S+4N (S+1024 for defaults). `Ocupado` falls at the same edge.
- Memory read contract: `DadoLido` must be valid before the rising edge that ends the `MenRead` cycle. The BIST adds no wait states.
- Result outputs are registered and update on the same edge as the compare.

## Test plan
- Fault-free behavioral memory, `Semente`=0xA5, `Iniciar` pulse:
  - first write cycle shows `Endereco`=0x00, `DadoEscr`=0xA5, `MenWrite`=1;
  - first pass-1 write shows `DadoEscr`=0x5A;
  - `Concluido`=1 after exactly 1024 cycles, with `NumErros`=0, `Falha`=0.
- Memory model with `DadoLido[0]` stuck at 0, `Semente`=0x00:
  - `NumErros`=256 (odd addresses in pass 0, even addresses in pass 1);
  - `PrimeiroEndErro`=0x01, `Falha`=1.
- Memory model corrupting only address 0x5A (returns data ^ 0x10):
  - `NumErros`=2, `PrimeiroEndErro`=0x5A.
- `Reset` driven low at cycle 300 of a run:
  - `MenWrite`, `MenRead` and `Ocupado` go to 0 before the next edge;
  - after release, a new `Iniciar` completes in 1024 cycles with clean results.
- `Iniciar` held high throughout a run:
  - the run is not restarted; `Concluido` after 1024 cycles;
  - the following edge in FIM restarts, clearing `NumErros` and `Concluido`.
- Bus protocol checker over a full run:
  - never `MenWrite`=`MenRead`=1;
  - `Endereco` increments by 1 each cycle and wraps 0xFF→0x00 at each phase change.
